// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one external combinational ALU. A request is
// accepted in IDLE, and its operands and op are registered onto the ALU
// inputs. The ALU result is captured one cycle later (EXEC). The result is
// then offered to the owning requester until that requester consumes it
// (RESP). Ties between the two requesters are broken round-robin.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/op        request handshake and payload (N=0,1)
//   respN_valid/ready/result/zero  response handshake and captured result
//   alu_a/alu_b/alu_op             registered ALU operands and op
//   alu_result                     combinational ALU output
//   busy                           a transaction is in flight
//   op_count                       completed transactions, wraps
module alu_share_arbiter #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic [3:0]           req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   input  logic [3:0]           req1_op,
   output logic                 resp0_valid,
   input  logic                 resp0_ready,
   output logic [WIDTH-1:0]     resp0_result,
   output logic                 resp0_zero,
   output logic                 resp1_valid,
   input  logic                 resp1_ready,
   output logic [WIDTH-1:0]     resp1_result,
   output logic                 resp1_zero,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [3:0]           alu_op,
   input  logic [WIDTH-1:0]     alu_result,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 owner_q;
   logic                 last_grant_q;
   logic [WIDTH-1:0]     alu_a_q, alu_b_q;
   logic [3:0]           alu_op_q;
   logic [WIDTH-1:0]     res0_q, res1_q;
   logic                 zero0_q, zero1_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic                 grant1;
   logic                 accept;
   logic                 consume;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grant and handshake outputs
   always_comb begin
      state_d     = state_q;
      grant1      = 1'b0;
      accept      = 1'b0;
      consume     = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // Ready is held low while reset is asserted, so no output
            // glitches high before the first edge after reset is released.
            if (!reset && (req0_valid || req1_valid)) begin
               // Requester 1 wins when it is alone, or when both requesters
               // are valid and requester 0 was granted last.
               grant1     = req1_valid && (!req0_valid || !last_grant_q);
               req0_ready = !grant1;
               req1_ready = grant1;
               accept     = 1'b1;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            resp0_valid = !owner_q;
            resp1_valid = owner_q;
            // Only the owner's ready is looked at; the other is ignored.
            consume     = owner_q ? resp1_ready : resp0_ready;
            if (consume) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand latch, result capture and completion counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         res0_q       <= '0;
         res1_q       <= '0;
         zero0_q      <= 1'b0;
         zero1_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (accept) begin
            alu_a_q      <= grant1 ? req1_a  : req0_a;
            alu_b_q      <= grant1 ? req1_b  : req0_b;
            alu_op_q     <= grant1 ? req1_op : req0_op;
            owner_q      <= grant1;
            last_grant_q <= grant1;
         end
         if (state_q == EXEC) begin
            if (owner_q) begin
               res1_q  <= alu_result;
               zero1_q <= (alu_result == '0);
            end else begin
               res0_q  <= alu_result;
               zero0_q <= (alu_result == '0);
            end
         end
         if (consume) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign resp0_result = res0_q;
   assign resp0_zero   = zero0_q;
   assign resp1_result = res1_q;
   assign resp1_zero   = zero1_q;
   assign busy         = (state_q != IDLE);
   assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random
// traffic with random backpressure and occasional resets.
module tb_alu_share_arbiter;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]    req0_op = '0, req1_op = '0;
   logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic          req0_ready, req1_ready;
   logic          resp0_valid, resp1_valid, resp0_zero, resp1_zero;
   logic [W-1:0]  resp0_result, resp1_result;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [3:0]    alu_op;
   logic          busy;
   logic [CW-1:0] op_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in for the shared ALU
   function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
      logic [W-1:0] d;
      d = a - b;
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return d;
         4'b1110: return {{(W-1){1'b0}}, d[W-1]};
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = ref_alu(alu_a, alu_b, alu_op);

   alu_share_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_result(resp0_result), .resp0_zero(resp0_zero),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_result(resp1_result), .resp1_zero(resp1_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .busy(busy), .op_count(op_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // phase: 0 = nothing in flight, 1 = result being computed,
   // 2 = result waiting for its owner
   int           m_phase, m_owner, m_last, m_cnt, m_w;
   logic [W-1:0] m_a, m_b;
   logic [3:0]   m_op;
   logic [W-1:0] m_res [2];
   logic         m_zero [2];
   bit           acc [2];

   // Which requester is granted right now (-1: none)
   function automatic int m_winner();
      if (reset || m_phase != 0) return -1;
      if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      if (reset) begin
         m_phase = 0; m_owner = 0; m_last = 1; m_cnt = 0;
         m_a = '0; m_b = '0; m_op = '0;
         m_res[0] = '0; m_res[1] = '0; m_zero[0] = 1'b0; m_zero[1] = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               m_w = m_winner();
               if (m_w >= 0) begin
                  m_owner = m_w;
                  m_last  = m_w;
                  m_a  = (m_w == 1) ? req1_a  : req0_a;
                  m_b  = (m_w == 1) ? req1_b  : req0_b;
                  m_op = (m_w == 1) ? req1_op : req0_op;
                  acc[m_w] = 1'b1;
                  m_phase = 1;
               end
            end
            1: begin
               m_res[m_owner]  = ref_alu(m_a, m_b, m_op);
               m_zero[m_owner] = (m_res[m_owner] == '0);
               m_phase = 2;
            end
            default: begin
               if ((m_owner == 0) ? resp0_ready : resp1_ready) begin
                  m_cnt = (m_cnt + 1) % (1 << CW);
                  m_phase = 0;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   int c_w;
   always @(negedge clk) begin
      c_w = m_winner();
      chk("req0_ready", req0_ready, c_w == 0);
      chk("req1_ready", req1_ready, c_w == 1);
      chk("resp0_valid", resp0_valid, m_phase == 2 && m_owner == 0);
      chk("resp1_valid", resp1_valid, m_phase == 2 && m_owner == 1);
      chk("resp0_result", resp0_result, m_res[0]);
      chk("resp1_result", resp1_result, m_res[1]);
      chk("resp0_zero", resp0_zero, m_zero[0]);
      chk("resp1_zero", resp1_zero, m_zero[1]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("busy", busy, m_phase != 0);
      chk("op_count", op_count, m_cnt);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rnd_payload(output logic [W-1:0] a, output logic [W-1:0] b,
                              output logic [3:0] op);
      logic [3:0] ops [6];
      ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b1110;
      ops[3] = 4'b0000; ops[4] = 4'b0001; ops[5] = 4'($urandom);
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) begin
         a = W'($urandom_range(0, 3));
         b = W'($urandom_range(0, 3));
      end else begin
         a = W'($urandom);
         b = W'($urandom);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("lit_rst_busy", busy, 0);
      chk("lit_rst_cnt", op_count, 0);
      chk("lit_rst_alu_a", alu_a, 0);
      chk("lit_rst_resp0_valid", resp0_valid, 0);
      reset = 1'b0;
      tick();

      // Single ADD 5+3 from requester 0
      req0_a = 5; req0_b = 3; req0_op = 4'b0010; req0_valid = 1'b1; resp0_ready = 1'b1;
      #1;
      chk("lit_add_ready", req0_ready, 1);
      tick();
      chk("lit_add_busy", busy, 1);
      chk("lit_add_alu_a", alu_a, 5);
      chk("lit_add_alu_op", alu_op, 4'b0010);
      chk("lit_add_ready_exec", req0_ready, 0);
      req0_valid = 1'b0;
      tick();
      chk("lit_add_resp_valid", resp0_valid, 1);
      chk("lit_add_result", resp0_result, 8);
      chk("lit_add_zero", resp0_zero, 0);
      chk("lit_add_resp1_valid", resp1_valid, 0);
      tick();
      chk("lit_add_cnt", op_count, 1);
      chk("lit_add_idle", busy, 0);
      chk("lit_add_resp_drop", resp0_valid, 0);

      // SLT on requester 1, then SUB giving zero
      req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_op = 4'b1110; req1_valid = 1'b1; resp1_ready = 1'b1;
      #1;
      chk("lit_slt_ready", req1_ready, 1);
      tick(); req1_valid = 1'b0;
      tick();
      chk("lit_slt_valid", resp1_valid, 1);
      chk("lit_slt_result", resp1_result, 32'h0000_0001);
      chk("lit_slt_zero", resp1_zero, 0);
      tick();
      req1_a = 1; req1_b = 1; req1_op = 4'b0110; req1_valid = 1'b1;
      tick(); req1_valid = 1'b0;
      tick();
      chk("lit_sub_result", resp1_result, 0);
      chk("lit_sub_zero", resp1_zero, 1);
      tick();
      chk("lit_sub_cnt", op_count, 3);

      // Contention: both valid continuously after reset
      reset = 1'b1; tick(); reset = 1'b0;
      req0_a = 10; req0_b = 20; req0_op = 4'b0010; req0_valid = 1'b1; resp0_ready = 1'b1;
      req1_a = 7;  req1_b = 2;  req1_op = 4'b0110; req1_valid = 1'b1; resp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("lit_cont_grant0", req0_ready, (k % 2) == 0);
         chk("lit_cont_grant1", req1_ready, (k % 2) == 1);
         tick(); tick();
         chk("lit_cont_resp0", resp0_valid, (k % 2) == 0);
         chk("lit_cont_resp1", resp1_valid, (k % 2) == 1);
         chk("lit_cont_res", (k % 2 == 0) ? resp0_result : resp1_result, (k % 2 == 0) ? 30 : 5);
         tick();
      end
      chk("lit_cont_cnt", op_count, 4);

      // Backpressure on requester 0 while requester 1 waits
      req0_a = 100; req0_b = 1; req0_op = 4'b0110; resp0_ready = 1'b0;
      req1_a = 3;   req1_b = 4; req1_op = 4'b0010;
      #1;
      chk("lit_bp_grant0", req0_ready, 1);
      chk("lit_bp_grant1", req1_ready, 0);
      tick(); req0_valid = 1'b0;
      tick();
      repeat (4) begin
         chk("lit_bp_valid", resp0_valid, 1);
         chk("lit_bp_result", resp0_result, 99);
         chk("lit_bp_req1_ready", req1_ready, 0);
         tick();
      end
      resp0_ready = 1'b1;
      #1;
      chk("lit_bp_req1_still_blocked", req1_ready, 0);
      tick();
      chk("lit_bp_req1_ready_next", req1_ready, 1);
      chk("lit_bp_resp0_drop", resp0_valid, 0);
      tick(); req1_valid = 1'b0;
      tick();
      chk("lit_bp_resp1_result", resp1_result, 7);
      tick();
      chk("lit_bp_cnt", op_count, 6);

      // Reset during EXEC
      req0_a = 1; req0_b = 2; req0_op = 4'b0010; req0_valid = 1'b1;
      tick(); req0_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("lit_rx_busy", busy, 0);
      chk("lit_rx_cnt", op_count, 0);
      chk("lit_rx_alu_a", alu_a, 0);
      chk("lit_rx_res0", resp0_result, 0);
      chk("lit_rx_res1", resp1_result, 0);
      tick(); reset = 1'b0;
      repeat (3) begin
         tick();
         chk("lit_rx_no_resp0", resp0_valid, 0);
         chk("lit_rx_no_resp1", resp1_valid, 0);
      end
      req1_a = 2; req1_b = 2; req1_op = 4'b0010; req1_valid = 1'b1;
      tick(); req1_valid = 1'b0;
      tick();
      chk("lit_rx_after_valid", resp1_valid, 1);
      chk("lit_rx_after_result", resp1_result, 4);
      tick();
      chk("lit_rx_after_cnt", op_count, 1);

      // Counter wrap with a 4-bit counter
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req0_a = W'(i); req0_b = 1; req0_op = 4'b0010; req0_valid = 1'b1;
         tick(); req0_valid = 1'b0;
         tick(); tick();
         if (i == 14) chk("lit_wrap_15", op_count, 15);
      end
      chk("lit_wrap_0", op_count, 0);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if (acc[0]) req0_valid = 1'b0;
         if (acc[1]) req1_valid = 1'b0;
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            rnd_payload(req0_a, req0_b, req0_op);
            req0_valid = 1'b1;
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            rnd_payload(req1_a, req1_b, req1_op);
            req1_valid = 1'b1;
         end
         resp0_ready = ($urandom_range(0, 3) != 0);
         resp1_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
